gate_sweep_ctrl: RTL and testbench

//  Sequencer for a small combinational gate under test (AND/OR/XOR/...).
//  On start it steps the gate's inputs through all 2^N_IN combinations, holds each one
//  for HOLD_CYCLES clocks, then samples y and checks it against a truth-table parameter.
//  It reports busy/done/pass, an error count and the first failing vector.

---
 rtl/gate_sweep_pkg.sv | 18 +
 rtl/gate_sweep_ctrl_hold_timer.sv | 32 +++
 rtl/gate_sweep_ctrl.sv | 105 ++++++++++
 tb/tb_gate_sweep_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
// Truth tables are indexed by the applied vector: expected y = TT[vec].
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_sweep_ctrl_hold_timer.sv
// Per-vector settle timer: loadable up-counter with clear/enable.
// tc marks the last hold cycle (count HOLD_CYCLES-1).
module sweep_hold_timer #(
   parameter int HOLD_CYCLES = 100,
   parameter int HW          = $clog2(HOLD_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          load,
   input  logic [HW-1:0] ld_val,
   output logic          tc
);

   logic [HW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= ld_val;
      end else if (en) begin
         cnt <= cnt + HW'(1);
      end
   end

   assign tc = (cnt == HW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of a small gate under test:
// apply, hold, sample, compare; reports pass, error count, first fail.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int                    N_IN        = 2,
   parameter int                    HOLD_CYCLES = 100,
   parameter logic [(1<<N_IN)-1:0]  TRUTH       = TT_AND2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] vec,
   input  logic            y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] fail_vec
);

   localparam int EW = N_IN + 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [EW-1:0] ERR_MAX = EW'(1 << N_IN);

   state_t        state;
   logic          first_fail;
   logic          hold_tc;
   logic          hold_clr;
   logic          hold_en;
   logic          mism;
   logic [EW-1:0] err_nxt;

   // Counter is idle outside APPLY, so clearing it throughout SAMPLE is harmless.
   assign hold_clr = (state == ST_SAMPLE) ||
                     (((state == ST_IDLE) || (state == ST_DONE)) && start);
   assign hold_en  = (state == ST_APPLY);

   sweep_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HW          (HW)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (hold_clr),
      .en     (hold_en),
      .load   (1'b0),
      .ld_val ('0),
      .tc     (hold_tc)
   );

   assign mism    = (y != TRUTH[vec]);
   assign err_nxt = (mism && (err_count != ERR_MAX)) ? err_count + EW'(1)
                                                     : err_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
         first_fail <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_APPLY;
                  vec        <= '0;
                  err_count  <= '0;
                  fail_vec   <= '0;
                  first_fail <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            ST_APPLY: begin
               if (hold_tc) state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               err_count <= err_nxt;
               if (mism && !first_fail) begin
                  fail_vec   <= vec;
                  first_fail <= 1'b1;
               end
               if (&vec) begin
                  state <= ST_DONE;
                  vec   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end else begin
                  state <= ST_APPLY;
                  vec   <= vec + N_IN'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench: drivers push expected sweep results, a negedge
// monitor pops and compares each time a DUT raises done.
module tb_gate_sweep_ctrl;
   import gate_sweep_pkg::*;

   typedef struct {
      int id;
      int lat;
      int err;
      int fail;
      int pass;
      int nvec;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_s [3];
   int   mode = 0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb [$];

   logic [1:0] vec0, fail0;
   logic [2:0] err0;
   logic       y0, busy0, done0, pass0;
   logic [1:0] vec1, fail1;
   logic [2:0] err1;
   logic       y1, busy1, done1, pass1;
   logic [2:0] vec2, fail2;
   logic [3:0] err2;
   logic       y2, busy2, done2, pass2;

   logic       done_w [3];
   logic       busy_w [3];
   logic       pass_w [3];
   logic [2:0] vec_w  [3];
   logic [2:0] fail_w [3];
   logic [3:0] err_w  [3];

   int start_cyc [3];
   int nvec      [3];
   int last_vec  [3];
   bit was_busy  [3];
   bit done_prev [3];
   bit overlap   [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign y0 = (mode == 0) ? (&vec0) : (mode == 1) ? 1'b0 : ~(&vec0);
   assign y1 = &vec1;
   assign y2 = &vec2;

   gate_sweep_ctrl u_dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .vec(vec0), .y(y0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0), .fail_vec(fail0));

   gate_sweep_ctrl #(.N_IN(2), .HOLD_CYCLES(1), .TRUTH(TT_AND2)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .vec(vec1), .y(y1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_vec(fail1));

   gate_sweep_ctrl #(.N_IN(3), .HOLD_CYCLES(100), .TRUTH(8'b1000_0000)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_s[2]), .vec(vec2), .y(y2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2), .fail_vec(fail2));

   assign done_w[0] = done0; assign busy_w[0] = busy0; assign pass_w[0] = pass0;
   assign vec_w[0]  = {1'b0, vec0};  assign fail_w[0] = {1'b0, fail0};
   assign err_w[0]  = {1'b0, err0};
   assign done_w[1] = done1; assign busy_w[1] = busy1; assign pass_w[1] = pass1;
   assign vec_w[1]  = {1'b0, vec1};  assign fail_w[1] = {1'b0, fail1};
   assign err_w[1]  = {1'b0, err1};
   assign done_w[2] = done2; assign busy_w[2] = busy2; assign pass_w[2] = pass2;
   assign vec_w[2]  = vec2;  assign fail_w[2] = fail2;
   assign err_w[2]  = err2;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Monitor: vector sequence tracking, busy/done exclusion, scoreboard pop.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (busy_w[d] && done_w[d]) overlap[d] = 1'b1;
         if (busy_w[d]) begin
            if (!was_busy[d]) begin
               chk($sformatf("dut%0d first_vec", d), int'(vec_w[d]), 0);
               nvec[d] = 1;
               last_vec[d] = int'(vec_w[d]);
            end else if (int'(vec_w[d]) != last_vec[d]) begin
               chk($sformatf("dut%0d vec_step", d), int'(vec_w[d]), last_vec[d] + 1);
               nvec[d]++;
               last_vec[d] = int'(vec_w[d]);
            end
         end
         was_busy[d] = busy_w[d];
         if (done_w[d] && !done_prev[d]) begin
            if (sb.size() == 0) begin
               chk($sformatf("dut%0d unexpected_done", d), 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("dut%0d done_id", d), d, e.id);
               chk($sformatf("dut%0d latency", d), cyc - start_cyc[d], e.lat);
               chk($sformatf("dut%0d err_count", d), int'(err_w[d]), e.err);
               chk($sformatf("dut%0d fail_vec", d), int'(fail_w[d]), e.fail);
               chk($sformatf("dut%0d pass", d), int'(pass_w[d]), e.pass);
               chk($sformatf("dut%0d nvec", d), nvec[d], e.nvec);
               chk($sformatf("dut%0d busy_done_overlap", d), int'(overlap[d]), 0);
               chk($sformatf("dut%0d vec_in_done", d), int'(vec_w[d]), 0);
            end
            overlap[d] = 1'b0;
         end
         done_prev[d] = done_w[d];
      end
   end

   task automatic expect_sweep(input int d, input int lat, input int err,
                               input int fail, input int pass, input int nv);
      exp_t e;
      e.id = d; e.lat = lat; e.err = err; e.fail = fail;
      e.pass = pass; e.nvec = nv;
      sb.push_back(e);
   endtask

   task automatic do_start(input int d);
      @(negedge clk);
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
      start_cyc[d] = cyc;
      chk($sformatf("dut%0d busy_after_start", d), int'(busy_w[d]), 1);
      chk($sformatf("dut%0d done_after_start", d), int'(done_w[d]), 0);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("sweep_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic chk_zero(input int d, input string tag);
      chk($sformatf("dut%0d %s vec", d, tag), int'(vec_w[d]), 0);
      chk($sformatf("dut%0d %s busy", d, tag), int'(busy_w[d]), 0);
      chk($sformatf("dut%0d %s done", d, tag), int'(done_w[d]), 0);
      chk($sformatf("dut%0d %s pass", d, tag), int'(pass_w[d]), 0);
      chk($sformatf("dut%0d %s err", d, tag), int'(err_w[d]), 0);
      chk($sformatf("dut%0d %s fail", d, tag), int'(fail_w[d]), 0);
   endtask

   initial begin
      int n;
      for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) chk_zero(d, "reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // good AND gate
      mode = 0;
      expect_sweep(0, 404, 0, 0, 1, 4);
      do_start(0);
      wait_drain(1000);

      // y stuck at 0: only vector 3 mismatches
      mode = 1;
      expect_sweep(0, 404, 1, 3, 0, 4);
      do_start(0);
      wait_drain(1000);

      // NAND checked against AND: every vector mismatches, count tops at 4
      mode = 2;
      expect_sweep(0, 404, 4, 0, 0, 4);
      do_start(0);
      wait_drain(1000);

      // reset during vec=2 hold
      mode = 0;
      do_start(0);
      n = 0;
      while (vec0 != 2'd2 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("dut0 reached_vec2", int'(vec0), 2);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero(0, "midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (450) @(negedge clk);
      chk("dut0 no_done_after_rst", int'(done0), 0);
      expect_sweep(0, 404, 0, 0, 1, 4);
      do_start(0);
      wait_drain(1000);

      // HOLD_CYCLES=1: restart attempt mid-sweep is ignored
      expect_sweep(1, 8, 0, 0, 1, 4);
      do_start(1);
      repeat (2) @(negedge clk);
      start_s[1] = 1'b1;
      @(negedge clk);
      start_s[1] = 1'b0;
      chk("dut1 busy_after_ignored_start", int'(busy1), 1);
      wait_drain(100);
      repeat (3) @(negedge clk);
      chk("dut1 done_held", int'(done1), 1);
      expect_sweep(1, 8, 0, 0, 1, 4);
      do_start(1);
      wait_drain(100);

      // three-input AND
      expect_sweep(2, 808, 0, 0, 1, 8);
      do_start(2);
      wait_drain(2000);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
